// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// - XLEN_DEF: default PC/data width.
// - PCSEL_*: next-PC select codes, identical to the decoder's pcsel encoding.
// - fetch_state_e: fetch FSM states.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN_DEF = 64;

  localparam logic [1:0] PCSEL_SEQ  = 2'b00;
  localparam logic [1:0] PCSEL_BR   = 2'b01;
  localparam logic [1:0] PCSEL_JALR = 2'b10;
  localparam logic [1:0] PCSEL_JAL  = 2'b11;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StHold  = 2'b01,
    StExec  = 2'b10,
    StFault = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch unit.
// Ports:
//   pc         in   XLEN  current PC
//   pcsel      in   2     seq / branch / jalr / jal
//   br_taken   in   1     branch outcome, only meaningful for branches
//   immediate  in   XLEN  sign-extended immediate
//   rs1_val    in   XLEN  jalr base register
//   next_pc    out  XLEN  selected target (modulo 2^XLEN)
//   misaligned out  1     target is not 4-byte aligned
module next_pc_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pcsel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] rs1_plus_imm;

  assign pc_plus_4    = pc + XLEN'(4);
  assign pc_plus_imm  = pc + immediate;
  assign rs1_plus_imm = rs1_val + immediate;

  always_comb begin
    next_pc = pc_plus_4;
    unique case (pcsel)
      PCSEL_SEQ:  next_pc = pc_plus_4;
      PCSEL_BR:   next_pc = br_taken ? pc_plus_imm : pc_plus_4;
      // jalr clears bit 0 of the computed target
      PCSEL_JALR: next_pc = {rs1_plus_imm[XLEN-1:1], 1'b0};
      PCSEL_JAL:  next_pc = pc_plus_imm;
      default:    next_pc = pc_plus_4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Non-pipelined fetch stage feeding the instruction decoder.
// Holds the PC, fetches one 32-bit word, presents it to the decoder and waits for the
// execute stage to resolve it before choosing the next PC.
// Ports:
//   clk, rst              clock, async active-high reset
//   imem_req/addr/ack/rdata   instruction memory interface (addr always equals pc)
//   inst/pc/inst_valid/inst_ready   decoder handshake
//   res_valid, pcsel, br_taken, immediate, rs1_val   resolution inputs from decode/execute
//   link_pc               pc+4 for link write-back
//   misalign              sticky misaligned-target fault
//   instret               resolved-instruction counter
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            res_valid,
  input  logic [1:0]      pcsel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] link_pc,
  output logic            misalign,
  output logic [63:0]     instret
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [63:0]     instret_q, instret_d;

  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  next_pc_calc #(
    .XLEN(XLEN)
  ) u_next_pc_calc (
    .pc        (pc_q),
    .pcsel     (pcsel),
    .br_taken  (br_taken),
    .immediate (immediate),
    .rs1_val   (rs1_val),
    .next_pc   (next_pc),
    .misaligned(next_misaligned)
  );

  // Inputs not relevant to the current state are simply not looked at.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        // res_valid here is ignored; resolution is only taken in StExec
        if (inst_ready) state_d = StExec;
      end
      StExec: begin
        if (res_valid) begin
          // The faulting target is still loaded so it is visible for debug.
          pc_d      = next_pc;
          instret_d = instret_q + 64'd1;
          state_d   = next_misaligned ? StFault : StFetch;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0;
      instret_q <= 64'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end

  // All status outputs decode directly from the state register.
  assign imem_req   = (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign inst_valid = (state_q == StHold);
  assign misalign   = (state_q == StFault);
  assign link_pc    = pc_q + XLEN'(4);
  assign instret    = instret_q;

endmodule
